alu_issue_stage: RTL
====================

# alu_issue_stage

Registered ID/EX issue stage that decodes a MIPS instruction into the ALU's control word (`ALUCtl`, `Sign`) and selects its two operands, then holds them in a pipeline register for the EX stage. It is the producing end of the ALU interface: every `ALUCtl`/`Sign`/`in_1`/`in_2` combination the ALU consumes originates here. It sits between the register-file read / forwarding logic and the ALU, with stall and flush controls from the hazard unit.

## Interface
- No parameters; the ALU control encoding below is fixed.
- `clk` input 1: system clock; all state updates on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: ID stage holds a real instruction.
- `instr` input 32: instruction word.
- `rs_data` input 32: forwarded rs operand.
- `rt_data` input 32: forwarded rt operand.
- `stall` input 1: hold the EX register unchanged.
- `flush` input 1: load a bubble into the EX register.
- `out_valid` output 1: EX register holds a real instruction.
- `alu_ctl` output 5: registered `ALUCtl`.
- `alu_sign` output 1: registered `Sign`.
- `alu_in_1` output 32: registered ALU operand 1 (shift amount for shifts).
- `alu_in_2` output 32: registered ALU operand 2.
- `illegal` output 1: registered; opcode/funct not decodable.

## Operation
- ALU control codes: AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, NOR 01100, XOR 01101, SLL 10000, SRL 11000, SRA 11001.
- Fields: op=instr[31:26], funct=instr[5:0], shamt=instr[10:6], imm=instr[15:0]; sext = {{16{imm[15]}},imm}, zext = {16'h0,imm}.
- R-type (op 000000), in_1=rs_data, in_2=rt_data unless noted:
  - add 100000 / addu 100001 → ADD, sign 1 / 0; sub 100010 / subu 100011 → SUB, sign 1 / 0.
  - and 100100, or 100101, xor 100110, nor 100111 → AND, OR, XOR, NOR, sign 0.
  - slt 101010 → SLT sign 1; sltu 101011 → SLT sign 0.
  - sll 000000, srl 000010, sra 000011 → SLL, SRL, SRA with in_1={27'h0,shamt}.
  - sllv 000100, srlv 000110, srav 000111 → SLL, SRL, SRA with in_1=rs_data (ALU uses in_1[4:0]).
- I-type, in_1=rs_data:
  - addi 001000 (sign 1), addiu 001001 (sign 0), lw 100011, sw 101011 (sign 0) → ADD, in_2=sext.
  - slti 001010 → SLT sign 1, in_2=sext; sltiu 001011 → SLT sign 0, in_2=sext.
  - andi 001100, ori 001101, xori 001110 → AND, OR, XOR, sign 0, in_2=zext.
  - lui 001111 → SLL, in_1=32'd16, in_2=zext.
  - beq 000100, bne 000101 → SUB sign 0, in_2=rt_data.
- Any other op/funct: illegal=1, alu_ctl=00000, sign 0, operands 0; out_valid follows in_valid.
- Bubble: out_valid=0, illegal=0, alu_ctl=00000, alu_sign=0, operands 0.

## Timing
- Reset (async assert, sync release): all outputs 0 (equivalent to a bubble).
- Latency 1 cycle: decode of `instr` at edge N appears on outputs after edge N.
- Priority per edge: flush > stall > load. Flush during stall loads a bubble.
- stall=1, flush=0: every output holds its value; inputs ignored.
- in_valid=0, no stall/flush: bubble loaded regardless of `instr`.
- Outputs are pure register outputs; no combinational path from inputs to outputs.
- reset_n asserted mid-stall or mid-flush: outputs go to 0 immediately; first edge after release performs a normal load.

## Test plan
- Reset: reset_n=0 with in_valid=1, instr=add → all outputs 0; release, next edge loads decode.
- R-type: add $3,$1,$2 (0x00221820), rs=5, rt=7 → after 1 edge: alu_ctl=00010, sign=1, in_1=5, in_2=7, out_valid=1.
- Shifts: sra $3,$2,4 (0x00021903), rt=0x80000000 → alu_ctl=11001, in_1=4, in_2=0x80000000; srav with rs=0x24 → in_1=0x24.
- Immediates: slti imm=0xFFFF → alu_ctl=00111, sign=1, in_2=0xFFFFFFFF; ori imm=0xFFFF → in_2=0x0000FFFF; lui 0x1234 → alu_ctl=10000, in_1=16, in_2=0x00001234.
- Hazards: load add, then stall=1 with new instr for 3 cycles → outputs unchanged; stall=1 and flush=1 same edge → bubble.
- Illegal: instr=0xFC000000, in_valid=1 → illegal=1, out_valid=1, alu_ctl=00000; next cycle in_valid=0 → illegal=0, out_valid=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes a MIPS instruction into ALU control/sign and operands, registered for EX.
// One cycle latency; stall holds the EX register, flush (higher priority) loads a bubble.
module alu_issue_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [4:0]  alu_ctl,
  output logic        alu_sign,
  output logic [31:0] alu_in_1,
  output logic [31:0] alu_in_2,
  output logic        illegal
);

  localparam logic [4:0] CTL_AND = 5'b00000;
  localparam logic [4:0] CTL_OR  = 5'b00001;
  localparam logic [4:0] CTL_ADD = 5'b00010;
  localparam logic [4:0] CTL_SUB = 5'b00110;
  localparam logic [4:0] CTL_SLT = 5'b00111;
  localparam logic [4:0] CTL_NOR = 5'b01100;
  localparam logic [4:0] CTL_XOR = 5'b01101;
  localparam logic [4:0] CTL_SLL = 5'b10000;
  localparam logic [4:0] CTL_SRL = 5'b11000;
  localparam logic [4:0] CTL_SRA = 5'b11001;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] sext;
  logic [31:0] zext;
  logic        unused_fields;

  assign op            = instr[31:26];
  assign funct         = instr[5:0];
  assign shamt         = instr[10:6];
  assign sext          = {{16{instr[15]}}, instr[15:0]};
  assign zext          = {16'h0, instr[15:0]};
  assign unused_fields = ^instr[25:16];

  logic [4:0]  dec_ctl;
  logic        dec_sign;
  logic [31:0] dec_in_1;
  logic [31:0] dec_in_2;
  logic        dec_legal;

  always_comb begin
    dec_ctl   = CTL_AND;
    dec_sign  = 1'b0;
    dec_in_1  = rs_data;
    dec_in_2  = rt_data;
    dec_legal = 1'b1;
    if (op == 6'b000000) begin
      case (funct)
        6'b100000: begin dec_ctl = CTL_ADD; dec_sign = 1'b1; end
        6'b100001: dec_ctl = CTL_ADD;
        6'b100010: begin dec_ctl = CTL_SUB; dec_sign = 1'b1; end
        6'b100011: dec_ctl = CTL_SUB;
        6'b100100: dec_ctl = CTL_AND;
        6'b100101: dec_ctl = CTL_OR;
        6'b100110: dec_ctl = CTL_XOR;
        6'b100111: dec_ctl = CTL_NOR;
        6'b101010: begin dec_ctl = CTL_SLT; dec_sign = 1'b1; end
        6'b101011: dec_ctl = CTL_SLT;
        6'b000000: begin dec_ctl = CTL_SLL; dec_in_1 = {27'h0, shamt}; end
        6'b000010: begin dec_ctl = CTL_SRL; dec_in_1 = {27'h0, shamt}; end
        6'b000011: begin dec_ctl = CTL_SRA; dec_in_1 = {27'h0, shamt}; end
        6'b000100: dec_ctl = CTL_SLL;
        6'b000110: dec_ctl = CTL_SRL;
        6'b000111: dec_ctl = CTL_SRA;
        default:   dec_legal = 1'b0;
      endcase
    end else begin
      case (op)
        6'b001000: begin dec_ctl = CTL_ADD; dec_sign = 1'b1; dec_in_2 = sext; end
        6'b001001, 6'b100011, 6'b101011: begin dec_ctl = CTL_ADD; dec_in_2 = sext; end
        6'b001010: begin dec_ctl = CTL_SLT; dec_sign = 1'b1; dec_in_2 = sext; end
        6'b001011: begin dec_ctl = CTL_SLT; dec_in_2 = sext; end
        6'b001100: begin dec_ctl = CTL_AND; dec_in_2 = zext; end
        6'b001101: begin dec_ctl = CTL_OR;  dec_in_2 = zext; end
        6'b001110: begin dec_ctl = CTL_XOR; dec_in_2 = zext; end
        6'b001111: begin dec_ctl = CTL_SLL; dec_in_1 = 32'd16; dec_in_2 = zext; end
        6'b000100, 6'b000101: dec_ctl = CTL_SUB;
        default:   dec_legal = 1'b0;
      endcase
    end
    // Undecodable words carry a clean all-zero control word downstream.
    if (!dec_legal) begin
      dec_ctl  = CTL_AND;
      dec_sign = 1'b0;
      dec_in_1 = 32'h0;
      dec_in_2 = 32'h0;
    end
  end

  logic        valid_q, valid_d;
  logic [4:0]  ctl_q, ctl_d;
  logic        sign_q, sign_d;
  logic [31:0] in_1_q, in_1_d;
  logic [31:0] in_2_q, in_2_d;
  logic        illegal_q, illegal_d;

  always_comb begin
    valid_d   = valid_q;
    ctl_d     = ctl_q;
    sign_d    = sign_q;
    in_1_d    = in_1_q;
    in_2_d    = in_2_q;
    illegal_d = illegal_q;
    if (flush || (!stall && !in_valid)) begin
      valid_d   = 1'b0;
      ctl_d     = 5'b0;
      sign_d    = 1'b0;
      in_1_d    = 32'h0;
      in_2_d    = 32'h0;
      illegal_d = 1'b0;
    end else if (!stall) begin
      valid_d   = 1'b1;
      ctl_d     = dec_ctl;
      sign_d    = dec_sign;
      in_1_d    = dec_in_1;
      in_2_d    = dec_in_2;
      illegal_d = !dec_legal;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      ctl_q     <= 5'b0;
      sign_q    <= 1'b0;
      in_1_q    <= 32'h0;
      in_2_q    <= 32'h0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      ctl_q     <= ctl_d;
      sign_q    <= sign_d;
      in_1_q    <= in_1_d;
      in_2_q    <= in_2_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_ctl   = ctl_q;
  assign alu_sign  = sign_q;
  assign alu_in_1  = in_1_q;
  assign alu_in_2  = in_2_q;
  assign illegal   = illegal_q;

endmodule
